// File: rtl/demux_rr_lanes.sv
// demux_rr_lanes: spreads each input stream round-robin over RATIO registered output channels
module demux_rr_lanes #(
    parameter int WIDTH = 8,
    parameter int NUM_IN = 2,
    parameter int RATIO = 2,
    localparam int NUM_OUT = NUM_IN * RATIO,
    localparam int SW = $clog2(RATIO)
) (
    input  logic                     clk_f,
    input  logic                     reset_L,
    input  logic [NUM_IN*WIDTH-1:0]  data_in,
    input  logic [NUM_IN-1:0]        valid_in,
    input  logic [NUM_IN-1:0]        align,
    output logic [NUM_OUT*WIDTH-1:0] data_out,
    output logic [NUM_OUT-1:0]       valid_out,
    output logic [NUM_IN-1:0]        group_done,
    output logic [NUM_IN*SW-1:0]     sel_out
);
    for (genvar i = 0; i < NUM_IN; i++) begin : g_s
        logic [SW-1:0] sel;
        logic [SW-1:0] slot;
        logic last;
        logic [RATIO*WIDTH-1:0] d;
        logic [RATIO-1:0] v;
        logic g;
        // a realigning beat lands in slot 0 regardless of the current selector
        always_comb begin
            slot = align[i] ? '0 : sel;
            last = slot == SW'(RATIO - 1);
        end
        always_ff @(posedge clk_f or negedge reset_L) begin
            if (!reset_L) begin
                sel <= '0;
                d <= '0;
                v <= '0;
                g <= 1'b0;
            end else begin
                v <= '0;
                g <= valid_in[i] && last;
                if (valid_in[i]) begin
                    d[slot*WIDTH +: WIDTH] <= data_in[i*WIDTH +: WIDTH];
                    v[slot] <= 1'b1;
                    sel <= last ? '0 : slot + 1'b1;
                end else if (align[i]) begin
                    sel <= '0;
                end
            end
        end
        assign data_out[i*RATIO*WIDTH +: RATIO*WIDTH] = d;
        assign valid_out[i*RATIO +: RATIO] = v;
        assign group_done[i] = g;
        assign sel_out[i*SW +: SW] = sel;
    end
endmodule

// File: tb/tb_demux_rr_lanes.sv
// tb_demux_rr_lanes: scoreboard bench for the default build and a 3-stream, 4-slot build
module tb_demux_rr_lanes;
    logic clk_f = 1'b0;
    always #5 clk_f = ~clk_f;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic [15:0] din_a;
    logic [1:0] valid_a, align_a;
    logic [31:0] dout_a;
    logic [3:0] vo_a;
    logic [1:0] gd_a, sel_a;
    logic [23:0] din_b;
    logic [2:0] valid_b, align_b;
    logic [95:0] dout_b;
    logic [11:0] vo_b;
    logic [2:0] gd_b;
    logic [5:0] sel_b;
    int errors = 0;
    int checks = 0;
    logic [39:0] qa[$];
    logic [116:0] qb[$];
    logic [39:0] pa;
    logic [116:0] pb;
    logic [31:0] ea_data = '0;
    logic [95:0] eb_data = '0;

    demux_rr_lanes dut_a (
        .clk_f(clk_f), .reset_L(reset_a), .data_in(din_a), .valid_in(valid_a), .align(align_a),
        .data_out(dout_a), .valid_out(vo_a), .group_done(gd_a), .sel_out(sel_a)
    );

    demux_rr_lanes #(.WIDTH(8), .NUM_IN(3), .RATIO(4)) dut_b (
        .clk_f(clk_f), .reset_L(reset_b), .data_in(din_b), .valid_in(valid_b), .align(align_b),
        .data_out(dout_b), .valid_out(vo_b), .group_done(gd_b), .sel_out(sel_b)
    );

    always @(negedge clk_f) begin
        if (reset_a && (vo_a != 0 || gd_a != 0)) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL mon_a: unexpected output vo=%b gd=%b data=%h", vo_a, gd_a, dout_a);
            end else begin
                pa = qa.pop_front();
                if ({vo_a, gd_a, sel_a, dout_a} !== pa) begin
                    errors++;
                    $display("FAIL mon_a: got vo=%b gd=%b sel=%b data=%h, want vo=%b gd=%b sel=%b data=%h",
                             vo_a, gd_a, sel_a, dout_a, pa[39:36], pa[35:34], pa[33:32], pa[31:0]);
                end
            end
        end
    end

    always @(negedge clk_f) begin
        if (reset_b && (vo_b != 0 || gd_b != 0)) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL mon_b: unexpected output vo=%b gd=%b data=%h", vo_b, gd_b, dout_b);
            end else begin
                pb = qb.pop_front();
                if ({vo_b, gd_b, sel_b, dout_b} !== pb) begin
                    errors++;
                    $display("FAIL mon_b: got vo=%b gd=%b sel=%b data=%h, want vo=%b gd=%b sel=%b data=%h",
                             vo_b, gd_b, sel_b, dout_b, pb[116:105], pb[104:102], pb[101:96], pb[95:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drive_a(input logic [1:0] v, input logic [1:0] al, input logic [15:0] d,
                           input logic [3:0] evo, input logic [1:0] egd, input logic [1:0] esel);
        @(posedge clk_f);
        #2;
        valid_a = v;
        align_a = al;
        din_a = d;
        for (int k = 0; k < 4; k++) if (evo[k]) ea_data[k*8 +: 8] = d[(k/2)*8 +: 8];
        if (evo != 0 || egd != 0) qa.push_back({evo, egd, esel, ea_data});
    endtask

    task automatic drive_b(input logic [2:0] v, input logic [23:0] d,
                           input logic [11:0] evo, input logic [2:0] egd, input logic [5:0] esel);
        @(posedge clk_f);
        #2;
        valid_b = v;
        align_b = '0;
        din_b = d;
        for (int k = 0; k < 12; k++) if (evo[k]) eb_data[k*8 +: 8] = d[(k/4)*8 +: 8];
        if (evo != 0 || egd != 0) qb.push_back({evo, egd, esel, eb_data});
    endtask

    initial begin
        din_a = '0; valid_a = '0; align_a = '0;
        din_b = '0; valid_b = '0; align_b = '0;
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        // reset held while inputs toggle
        repeat (3) begin
            @(posedge clk_f);
            #2;
            din_a = 16'($urandom); valid_a = 2'($urandom); align_a = 2'($urandom);
            din_b = 24'($urandom); valid_b = 3'($urandom); align_b = 3'($urandom);
        end
        @(negedge clk_f);
        chk("reset_a_outputs", {vo_a, gd_a, sel_a, dout_a}, '0);
        chk("reset_b_outputs", {vo_b, gd_b, sel_b, dout_b}, '0);
        @(posedge clk_f);
        #2;
        din_a = '0; valid_a = '0; align_a = '0;
        din_b = '0; valid_b = '0; align_b = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(posedge clk_f);
        @(negedge clk_f);
        chk("post_release_a", {vo_a, gd_a, sel_a, dout_a}, '0);
        chk("post_release_b", {vo_b, gd_b, sel_b, dout_b}, '0);

        // back-to-back beats on stream 0
        drive_a(2'b01, 2'b00, 16'h00A1, 4'b0001, 2'b00, 2'b01);
        drive_a(2'b01, 2'b00, 16'h00B2, 4'b0010, 2'b01, 2'b00);
        drive_a(2'b01, 2'b00, 16'h00C3, 4'b0001, 2'b00, 2'b01);
        drive_a(2'b01, 2'b00, 16'h00D4, 4'b0010, 2'b01, 2'b00);
        // stream 1 with idle gaps
        drive_a(2'b10, 2'b00, 16'h1100, 4'b0100, 2'b00, 2'b10);
        repeat (3) drive_a(2'b00, 2'b00, 16'hFFFF, 4'b0000, 2'b00, 2'b00);
        drive_a(2'b10, 2'b00, 16'h2200, 4'b1000, 2'b10, 2'b00);
        // align together with a beat
        drive_a(2'b01, 2'b00, 16'h0055, 4'b0001, 2'b00, 2'b01);
        drive_a(2'b01, 2'b01, 16'h0066, 4'b0001, 2'b00, 2'b01);
        drive_a(2'b01, 2'b00, 16'h0077, 4'b0010, 2'b01, 2'b00);
        // align alone resets the selector without producing output
        drive_a(2'b01, 2'b00, 16'h0088, 4'b0001, 2'b00, 2'b01);
        drive_a(2'b00, 2'b01, 16'h0000, 4'b0000, 2'b00, 2'b00);
        drive_a(2'b00, 2'b00, 16'h0000, 4'b0000, 2'b00, 2'b00);
        chk("align_idle_sel", 128'(sel_a), 128'(2'b00));
        drive_a(2'b01, 2'b00, 16'h0099, 4'b0001, 2'b00, 2'b01);
        drive_a(2'b01, 2'b00, 16'h009A, 4'b0010, 2'b01, 2'b00);
        // simultaneous beats on both streams
        drive_a(2'b11, 2'b00, 16'hF00F, 4'b0101, 2'b00, 2'b11);
        drive_a(2'b11, 2'b00, 16'h5AA5, 4'b1010, 2'b11, 2'b00);
        drive_a(2'b00, 2'b00, 16'h0000, 4'b0000, 2'b00, 2'b00);

        // 4-slot build: stream 2, reset after the second beat
        drive_b(3'b100, 24'h010000, 12'h100, 3'b000, 6'b010000);
        drive_b(3'b100, 24'h020000, 12'h200, 3'b000, 6'b100000);
        drive_b(3'b000, 24'h000000, 12'h000, 3'b000, 6'b000000);
        @(negedge clk_f);
        #1;
        reset_b = 1'b0;
        #1;
        chk("midgroup_reset_b", {vo_b, gd_b, sel_b, dout_b}, '0);
        eb_data = '0;
        @(posedge clk_f);
        #2;
        reset_b = 1'b1;
        drive_b(3'b100, 24'h030000, 12'h100, 3'b000, 6'b010000);
        drive_b(3'b100, 24'h040000, 12'h200, 3'b000, 6'b100000);
        drive_b(3'b100, 24'h050000, 12'h400, 3'b000, 6'b110000);
        drive_b(3'b100, 24'h060000, 12'h800, 3'b100, 6'b000000);
        drive_b(3'b100, 24'h070000, 12'h100, 3'b000, 6'b010000);
        drive_b(3'b100, 24'h080000, 12'h200, 3'b000, 6'b100000);
        drive_b(3'b000, 24'h000000, 12'h000, 3'b000, 6'b000000);

        for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) @(posedge clk_f);
        chk("drain_a", 128'(qa.size()), 128'(0));
        chk("drain_b", 128'(qb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
